// File: rtl/medidor_reacao_if.sv
// Player-facing signal bundle of the reaction-time meter.
// master: the side that drives tick/start/botao. slave: the meter itself.
`timescale 1ns/1ps
interface medidor_reacao_if;
    logic        tick_1ms;
    logic        start;
    logic        botao;
    logic        led_estimulo;
    logic [13:0] tempo_ms;
    logic        valido;
    logic        queima_largada;
    logic        estouro;
    logic        ocupado;

    modport master (
        output tick_1ms, start, botao,
        input  led_estimulo, tempo_ms, valido, queima_largada, estouro, ocupado
    );

    modport slave (
        input  tick_1ms, start, botao,
        output led_estimulo, tempo_ms, valido, queima_largada, estouro, ocupado
    );
endinterface

// File: rtl/medidor_reacao.sv
// Reaction-time meter: waits a pseudo-random delay, lights the stimulus lamp,
// then counts milliseconds until the player presses the button.
//
// state   | meaning
// OCIOSO  | idle after reset, waiting for start
// ESPERA  | random delay running, lamp off; a press here is a false start
// MEDINDO | lamp on, tempo_ms counting 1 ms ticks
// FIM     | round over, result and flags held until the next start
`timescale 1ns/1ps
module medidor_reacao #(
    parameter int ATRASO_MIN  = 1000,
    parameter int ATRASO_MASK = 4095,
    parameter int TEMPO_MAX   = 9999
) (
    input  logic              clk,
    input  logic              reset,
    medidor_reacao_if.slave   bus
);

    typedef enum logic [1:0] {OCIOSO, ESPERA, MEDINDO, FIM} estado_t;

    localparam logic [15:0] SEMENTE = 16'hACE1;
    localparam logic [13:0] LIMITE  = 14'(TEMPO_MAX);

    estado_t     estado, estado_n;
    logic [15:0] lfsr;
    logic        realim;
    logic [31:0] atraso, atraso_n;

    logic        led_q, led_n;
    logic [13:0] tempo_q, tempo_n;
    logic        valido_q, valido_n;
    logic        queima_q, queima_n;
    logic        estouro_q, estouro_n;
    logic        ocupado_q, ocupado_n;

    // Taps 16/14/13/11 give a maximal-length sequence, so a non-zero seed never hits zero.
    assign realim = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // LFSR free-runs every clock so the start instant decides the delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= SEMENTE;
        else       lfsr <= {lfsr[14:0], realim};
    end

    // State, delay counter and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            atraso    <= '0;
            led_q     <= 1'b0;
            tempo_q   <= '0;
            valido_q  <= 1'b0;
            queima_q  <= 1'b0;
            estouro_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado    <= estado_n;
            atraso    <= atraso_n;
            led_q     <= led_n;
            tempo_q   <= tempo_n;
            valido_q  <= valido_n;
            queima_q  <= queima_n;
            estouro_q <= estouro_n;
            ocupado_q <= ocupado_n;
        end
    end

    // Next-state and next-output decode; a press always outranks a tick in the same cycle.
    always_comb begin
        estado_n  = estado;
        atraso_n  = atraso;
        led_n     = led_q;
        tempo_n   = tempo_q;
        valido_n  = valido_q;
        queima_n  = queima_q;
        estouro_n = estouro_q;

        case (estado)
            OCIOSO, FIM: begin
                if (bus.start) begin
                    atraso_n  = 32'(ATRASO_MIN) + (32'(lfsr) & 32'(ATRASO_MASK));
                    led_n     = 1'b0;
                    tempo_n   = '0;
                    valido_n  = 1'b0;
                    queima_n  = 1'b0;
                    estouro_n = 1'b0;
                    estado_n  = ESPERA;
                end
            end
            ESPERA: begin
                if (bus.botao) begin
                    queima_n = 1'b1;
                    led_n    = 1'b0;
                    estado_n = FIM;
                end else if (bus.tick_1ms) begin
                    // <= 1 also catches a zero-length delay so the round cannot stall.
                    if (atraso <= 32'd1) begin
                        atraso_n = '0;
                        led_n    = 1'b1;
                        tempo_n  = '0;
                        estado_n = MEDINDO;
                    end else begin
                        atraso_n = atraso - 32'd1;
                    end
                end
            end
            MEDINDO: begin
                if (bus.botao) begin
                    valido_n = 1'b1;
                    led_n    = 1'b0;
                    estado_n = FIM;
                end else if (bus.tick_1ms) begin
                    if (tempo_q >= LIMITE) begin
                        estouro_n = 1'b1;
                        led_n     = 1'b0;
                        estado_n  = FIM;
                    end else begin
                        tempo_n = tempo_q + 14'd1;
                    end
                end
            end
            default: estado_n = OCIOSO;
        endcase

        ocupado_n = (estado_n == ESPERA) || (estado_n == MEDINDO);
    end

    assign bus.led_estimulo   = led_q;
    assign bus.tempo_ms       = tempo_q;
    assign bus.valido         = valido_q;
    assign bus.queima_largada = queima_q;
    assign bus.estouro        = estouro_q;
    assign bus.ocupado        = ocupado_q;

endmodule

// File: doc/medidor_reacao.md
MEDIDOR_REACAO -- requirements
Module: medidor_reacao

Interface
REQ-001 Parameter ATRASO_MIN, default 1000, minimum random stimulus delay in ms.
REQ-002 Parameter ATRASO_MASK, default 4095, mask applied to the LFSR to form the random delay span.
REQ-003 Parameter TEMPO_MAX, default 9999, saturation limit of the measured time in ms.
REQ-004 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick_1ms  input  1  one-clk-wide pulse every 1 ms from the upstream millisecond pulse generator.
REQ-007 start  input  1  synchronous round-start request, sampled each clk.
REQ-008 botao  input  1  player button, already synchronised and debounced, 1 = pressed.
REQ-009 led_estimulo  output  1  stimulus lamp, 1 while measuring.
REQ-010 tempo_ms  output  14  measured reaction time in ms.
REQ-011 valido  output  1  1 when tempo_ms holds a valid reaction result.
REQ-012 queima_largada  output  1  1 when the last round ended in a false start.
REQ-013 estouro  output  1  1 when the last round hit TEMPO_MAX without a press.
REQ-014 ocupado  output  1  1 while in ESPERA or MEDINDO.

Function
REQ-015 FSM states OCIOSO, ESPERA, MEDINDO, FIM; all outputs registered.
REQ-016 16-bit Fibonacci LFSR, taps 16/14/13/11, seed 16'hACE1, advances every clk in all states, never reaches zero.
REQ-017 OCIOSO or FIM with start=1: load delay counter = ATRASO_MIN + (lfsr & ATRASO_MASK), clear tempo_ms, valido, queima_largada, estouro; next state ESPERA.
REQ-018 start in ESPERA or MEDINDO is ignored.
REQ-019 ESPERA: each tick_1ms decrements the delay counter; the tick with counter==1 moves to MEDINDO, sets led_estimulo=1, tempo_ms=0.
REQ-020 ESPERA with botao=1 (including held from round start): queima_largada=1, led_estimulo=0, next state FIM; botao wins over a simultaneous final tick.
REQ-021 MEDINDO: each tick_1ms increments tempo_ms by 1.
REQ-022 MEDINDO with botao=1: valido=1, led_estimulo=0, tempo_ms frozen, next state FIM; a tick in the same cycle does not increment.
REQ-023 MEDINDO tick with tempo_ms==TEMPO_MAX: no increment, estouro=1, led_estimulo=0, next state FIM; tempo_ms never exceeds TEMPO_MAX.
REQ-024 FIM holds tempo_ms and flags until next start; exactly one of valido/queima_largada/estouro is 1 in FIM.
REQ-025 ocupado = 1 exactly in ESPERA and MEDINDO.
REQ-026 Stimulus delay is ATRASO_MIN..ATRASO_MIN+ATRASO_MASK ms, accurate to within one tick period of the round start.

Reset
REQ-027 reset=1 asynchronously forces state OCIOSO, LFSR=16'hACE1, delay counter=0, all outputs 0, at any time including mid-round.
REQ-028 After reset deassertion the block accepts start on the first clk edge.

Verification
REQ-029 ATRASO_MASK=0, ATRASO_MIN=3; start, botao low, botao=1 one clk after the 5th tick -> led_estimulo rises on tick 3, FIM with tempo_ms=2, valido=1.
REQ-030 ATRASO_MASK=0, ATRASO_MIN=3; start, botao=1 after tick 1 -> queima_largada=1, led_estimulo never 1, tempo_ms=0.
REQ-031 ATRASO_MASK=0, ATRASO_MIN=1, TEMPO_MAX=5; no press -> tempo_ms stops at 5, estouro=1, led_estimulo=0, state FIM.
REQ-032 In MEDINDO at tempo_ms=7, botao and tick_1ms same cycle -> tempo_ms=7, valido=1.
REQ-033 reset pulsed mid-MEDINDO (tempo_ms=40) -> all outputs 0 immediately, ocupado=0; next start begins a normal round.
REQ-034 Default parameters, 1000 rounds with random start timing -> every stimulus delay within 1000..5095 ms; start during ocupado=1 has no effect.
